// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } tx_state_e;

  localparam int unsigned DEF_PRESCALE   = 3;
  localparam int unsigned DEF_OVERSAMPLE = 16;
  localparam int unsigned DEF_GAP_BITS   = 6;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_PARITY_EN  = 1;

  // Serial bits per frame: start + 8 data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned parity_en);
    return 10 + ((parity_en != 0) ? 1 : 0);
  endfunction

  localparam int unsigned FRAME_BITS = 10 + DEF_PARITY_EN;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and a registered level.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/parity/stop/gap serializer.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE   = DEF_PRESCALE,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned PARITY_EN  = DEF_PARITY_EN,
  parameter int unsigned GAP_BITS   = DEF_GAP_BITS
) (
  input  logic                        Clk,
  input  logic                        Rstn,
  input  logic [7:0]                  PalDataIn,
  input  logic                        PalDataInValid,
  output logic                        PalDataInReady,
  output logic                        SerDataOut,
  output logic                        TxBusy,
  output logic [$clog2(FIFO_DEPTH):0] FifoLevel
);

  localparam int unsigned PW       = $clog2(PRESCALE);
  localparam int unsigned TW       = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_MAX = (GAP_BITS > 8) ? GAP_BITS : 8;
  localparam int unsigned BW       = $clog2(BCNT_MAX);

  logic [PW-1:0] presc_cnt;
  logic          tick;
  tx_state_e     state;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [7:0]    shift;
  logic          parity;
  logic          bit_end;
  logic          frame_done;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_data;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Rstn),
    .wr_data (PalDataIn),
    .wr_en   (PalDataInValid),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (FifoLevel)
  );

  assign PalDataInReady = !fifo_full;
  assign bit_end        = (tick_cnt == TW'(OVERSAMPLE - 1));

  // Free-running prescaler; tick is a registered one-clock pulse per wrap.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      presc_cnt <= '0;
      tick      <= 1'b0;
    end else begin
      tick      <= (presc_cnt == PW'(PRESCALE - 1));
      presc_cnt <= (presc_cnt == PW'(PRESCALE - 1)) ? '0 : presc_cnt + 1'b1;
    end
  end

  // Flags the last tick of the final idle-high period of a frame.
  always_comb begin
    frame_done = 1'b0;
    if (bit_end) begin
      if (state == GAP && bit_cnt == BW'(GAP_BITS - 1)) begin
        frame_done = 1'b1;
      end
      if (state == STOP && GAP_BITS == 0) begin
        frame_done = 1'b1;
      end
    end
  end

  // Frame end passes through IDLE in zero time: a queued byte starts on that
  // same tick, which keeps the back-to-back pitch equal to frame plus gap.
  assign pop = tick && !fifo_empty && (state == IDLE || frame_done);

  // Serializer FSM; every state or output change happens on a tick.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state      <= IDLE;
      SerDataOut <= 1'b1;
      TxBusy     <= 1'b0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity     <= 1'b0;
    end else if (tick) begin
      if (pop) begin
        shift      <= fifo_data;
        parity     <= ~^fifo_data;
        SerDataOut <= 1'b0;
        TxBusy     <= 1'b1;
        tick_cnt   <= '0;
        state      <= START;
      end else if (state == IDLE) begin
        tick_cnt <= '0;
      end else if (!bit_end) begin
        tick_cnt <= tick_cnt + 1'b1;
      end else begin
        tick_cnt <= '0;
        case (state)
          START: begin
            SerDataOut <= shift[0];
            shift      <= {1'b0, shift[7:1]};
            bit_cnt    <= '0;
            state      <= DATA;
          end
          DATA: begin
            if (bit_cnt != BW'(7)) begin
              SerDataOut <= shift[0];
              shift      <= {1'b0, shift[7:1]};
              bit_cnt    <= bit_cnt + 1'b1;
            end else if (PARITY_EN != 0) begin
              SerDataOut <= parity;
              state      <= PARITY;
            end else begin
              SerDataOut <= 1'b1;
              state      <= STOP;
            end
          end
          PARITY: begin
            SerDataOut <= 1'b1;
            state      <= STOP;
          end
          STOP: begin
            if (GAP_BITS > 0) begin
              bit_cnt <= '0;
              state   <= GAP;
            end else begin
              TxBusy <= 1'b0;
              state  <= IDLE;
            end
          end
          GAP: begin
            if (bit_cnt == BW'(GAP_BITS - 1)) begin
              TxBusy <= 1'b0;
              state  <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            SerDataOut <= 1'b1;
            TxBusy     <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: per-cycle comparison against a frame-level model,
// an independent line decoder, and directed literal checks.
module tb_uart_frame_tx;

  localparam int unsigned P      = 3;
  localparam int unsigned OS     = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned GAPB   = 6;
  localparam int unsigned BITCLK = P * OS;
  localparam int unsigned NBITS  = 11;
  localparam int unsigned PITCH  = (NBITS + GAPB) * BITCLK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       ready, ser, busy;
  logic [2:0] level;
  logic [7:0] np_din = '0;
  logic       np_valid = 1'b0;
  logic       np_ready, np_ser, np_busy;
  logic [2:0] np_level;

  always #5 clk = ~clk;

  uart_frame_tx #(
    .PRESCALE(P), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .PARITY_EN(1), .GAP_BITS(GAPB)
  ) dut (
    .Clk(clk), .Rstn(rst_n), .PalDataIn(din), .PalDataInValid(din_valid),
    .PalDataInReady(ready), .SerDataOut(ser), .TxBusy(busy), .FifoLevel(level)
  );

  uart_frame_tx #(
    .PRESCALE(P), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .PARITY_EN(0), .GAP_BITS(0)
  ) dut_np (
    .Clk(clk), .Rstn(rst_n), .PalDataIn(np_din), .PalDataInValid(np_valid),
    .PalDataInReady(np_ready), .SerDataOut(np_ser), .TxBusy(np_busy), .FifoLevel(np_level)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as a bit list: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    f[10]  = 1'b1;
    return f;
  endfunction

  // ---------------- behavioural model ----------------
  byte unsigned m_q[$];
  byte unsigned exp_line_q[$];
  int           m_edge = 0;
  int           m_start = 0;
  bit           m_busy = 1'b0;
  logic [10:0]  m_bits = '1;
  int           rst_count = 0;
  bit           m_acc;
  byte unsigned m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      exp_line_q.delete();
      m_edge = 0;
      m_busy = 1'b0;
      rst_count++;
    end else begin
      m_acc = din_valid && (m_q.size() < DEPTH);
      m_edge++;
      if (m_edge >= int'(P + 1) && ((m_edge - 1) % P) == 0) begin
        if (m_busy && (m_edge - m_start) == int'(PITCH)) m_busy = 1'b0;
        if (!m_busy && m_q.size() > 0) begin
          m_b = m_q.pop_front();
          m_bits = frame_of(m_b);
          m_start = m_edge;
          m_busy = 1'b1;
          exp_line_q.push_back(m_b);
        end
      end
      if (m_acc) m_q.push_back(din);
    end
  end

  // Per-cycle comparison of every main-DUT output against the model.
  int   cmp_d;
  logic cmp_line;
  always @(negedge clk) begin
    cmp_line = 1'b1;
    if (m_busy) begin
      cmp_d = m_edge - m_start;
      if (cmp_d < int'(NBITS * BITCLK)) cmp_line = m_bits[cmp_d / BITCLK];
    end
    check("ser_line", ser, cmp_line);
    check("tx_busy", busy, m_busy);
    check("fifo_level", level, m_q.size());
    check("in_ready", ready, (m_q.size() != DEPTH));
  end

  // ---------------- independent line decoder ----------------
  bit           mon_prev = 1'b1;
  int           mon_rc;
  logic [10:0]  mon_fb;
  time          mon_t0;
  byte unsigned mon_exp;
  time          mon_t[$];
  byte unsigned dec_q[$];

  always @(negedge clk) begin
    if (rst_n && mon_prev && !ser) begin
      mon_rc = rst_count;
      mon_t0 = $time;
      repeat (BITCLK / 2) @(negedge clk);
      mon_fb[0] = ser;
      for (int b = 1; b < int'(NBITS); b++) begin
        repeat (BITCLK) @(negedge clk);
        mon_fb[b] = ser;
      end
      if (mon_rc == rst_count) begin
        mon_t.push_back(mon_t0);
        dec_q.push_back(mon_fb[8:1]);
        check("dec_start", mon_fb[0], 1'b0);
        check("dec_stop", mon_fb[10], 1'b1);
        check("dec_odd_ones", $countones(mon_fb[9:1]) % 2, 1);
        if (exp_line_q.size() == 0) begin
          check("dec_unexpected_frame", 1, 0);
        end else begin
          mon_exp = exp_line_q.pop_front();
          check("dec_data", mon_fb[8:1], mon_exp);
        end
      end
    end
    mon_prev = ser;
  end

  // ---------------- stimulus helpers ----------------
  bit saw_not_ready = 1'b0;

  task automatic push(input logic [7:0] b);
    logic r;
    din = b;
    din_valid = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      r = ready;
      if (!r) saw_not_ready = 1'b1;
      @(posedge clk);
      #1;
      if (r) begin
        din_valid = 1'b0;
        return;
      end
    end
    din_valid = 1'b0;
    check("push_timeout", 0, 1);
  endtask

  task automatic capture(input bit np, input int nb, output logic [10:0] fb,
                         output int bcnt, output logic [2:0] lvl0);
    bit found;
    found = 1'b0;
    fb = '1;
    bcnt = 0;
    lvl0 = '1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if ((np ? np_ser : ser) == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      check("capture_no_start", 0, 1);
    end else begin
      lvl0 = np ? np_level : level;
      for (int c = 0; c < 3000; c++) begin
        if ((c % BITCLK) == BITCLK / 2 && (c / BITCLK) < nb) fb[c / BITCLK] = np ? np_ser : ser;
        if (np ? np_busy : busy) bcnt++;
        else break;
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (!m_busy && m_q.size() == 0 && !din_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 0, 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_model_edge(input int offset, input int limit);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (m_busy && (m_edge - m_start) == offset) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!hit) check("edge_wait_timeout", 0, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [10:0] fb;
  int          bcnt;
  logic [2:0]  lvl0;
  int          quiet;
  logic        r;
  byte unsigned loop_bytes[4] = '{8'h00, 8'hFF, 8'h80, 8'h7E};

  initial begin
    // Reset state.
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_ser", ser, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_level", level, 3'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single 0xA5 frame.
    push(8'hA5);
    capture(1'b0, 11, fb, bcnt, lvl0);
    check("a5_bits", fb, 11'h74A);
    check("a5_busy_clocks", bcnt, 816);
    check("a5_level_at_start", lvl0, 3'd0);
    wait_idle(2000);

    // No-parity, no-gap instance with 0x00.
    np_din = 8'h00;
    np_valid = 1'b1;
    @(posedge clk);
    #1 np_valid = 1'b0;
    capture(1'b1, 10, fb, bcnt, lvl0);
    check("np_bits", fb[9:0], 10'h200);
    check("np_busy_clocks", bcnt, 480);
    check("np_ready_after", np_ready, 1'b1);

    // Six bytes back-to-back into a depth-4 FIFO.
    mon_t.delete();
    dec_q.delete();
    saw_not_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i));
    check("burst_ready_dropped", saw_not_ready, 1'b1);
    wait_idle(8000);
    check("burst_frames", mon_t.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < mon_t.size()) check("burst_order", dec_q[i], 8'(i + 1));
      if (i > 0 && i < mon_t.size()) check("burst_pitch", (mon_t[i] - mon_t[i - 1]) / 10, PITCH);
    end

    // Simultaneous write and pop with one byte queued.
    dec_q.delete();
    push(8'h3C);
    push(8'hC3);
    wait_model_edge(int'(PITCH) - 1, 2000);
    check("sim_level_before", level, 3'd1);
    din = 8'h96;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    @(negedge clk);
    check("sim_level_after", level, 3'd1);
    check("sim_busy_after", busy, 1'b1);
    @(posedge clk);
    #1;
    wait_idle(4000);
    check("sim_frames", dec_q.size(), 3);
    if (dec_q.size() == 3) begin
      check("sim_order0", dec_q[0], 8'h3C);
      check("sim_order1", dec_q[1], 8'hC3);
      check("sim_order2", dec_q[2], 8'h96);
    end

    // Reset pulse during data bit 3 of 0x5A with two bytes queued.
    push(8'h5A);
    push(8'h11);
    push(8'h22);
    wait_model_edge(4 * int'(BITCLK) + 24, 500);
    check("abort_busy_before", busy, 1'b1);
    check("abort_level_before", level, 3'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ser", ser, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_level", level, 3'd0);
    check("abort_ready", ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    quiet = 0;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      if (!ser || busy) quiet++;
    end
    check("abort_no_frames", quiet, 0);
    @(posedge clk);
    #1;

    // Loopback pattern bytes.
    dec_q.delete();
    foreach (loop_bytes[i]) push(loop_bytes[i]);
    wait_idle(5000);
    check("loop_frames", dec_q.size(), 4);
    foreach (loop_bytes[i]) if (i < dec_q.size()) check("loop_data", dec_q[i], loop_bytes[i]);

    // Random traffic.
    for (int c = 0; c < 12000; c++) begin
      @(negedge clk);
      r = ready;
      @(posedge clk);
      #1;
      if (din_valid && r) din_valid = 1'b0;
      if (!din_valid && $urandom_range(0, 15) == 0) begin
        din = 8'($urandom);
        din_valid = 1'b1;
      end
    end
    @(negedge clk);
    r = ready;
    @(posedge clk);
    #1;
    if (din_valid && !r) begin
      for (int n = 0; n < 1000 && din_valid; n++) begin
        @(negedge clk);
        r = ready;
        @(posedge clk);
        #1;
        if (r) din_valid = 1'b0;
      end
    end
    din_valid = 1'b0;
    wait_idle(6000);
    check("final_line_queue_empty", exp_line_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
